// File: rtl/intc_pkg.sv
// Shared definitions for the interrupt controller: register map, FSM states
// and the register data type.
package intc_pkg;

    localparam logic [2:0] ADDR_ENABLE     = 3'd0;
    localparam logic [2:0] ADDR_PENDING    = 3'd1;
    localparam logic [2:0] ADDR_TRIGGER    = 3'd2;
    localparam logic [2:0] ADDR_IN_SERVICE = 3'd3;
    localparam logic [2:0] ADDR_COMPLETE   = 3'd4;
    localparam logic [2:0] ADDR_STATUS     = 3'd5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        SERVICE = 2'd2
    } intc_state_e;

    typedef logic [31:0] reg_data_t;

endpackage

// File: rtl/interrupt_controller_if.sv
// Register bus plus CPU request/acknowledge signals of the interrupt controller.
// Handshake: irq_o stays high with vector_o stable until the CPU pulses ack_i for
// one cycle (or the request is withdrawn); COMPLETE with the vector closes service.
interface interrupt_controller_if #(
    parameter int VECTOR_WIDTH = 3
);
    import intc_pkg::*;

    logic                    write_i;
    reg_data_t               write_data_i;
    logic [2:0]              write_address_i;
    logic                    read_i;
    logic [2:0]              read_address_i;
    reg_data_t               read_data_o;
    logic                    irq_o;
    logic [VECTOR_WIDTH-1:0] vector_o;
    logic                    ack_i;

    modport slave (
        input  write_i, write_data_i, write_address_i,
        input  read_i, read_address_i, ack_i,
        output read_data_o, irq_o, vector_o
    );

    modport master (
        output write_i, write_data_i, write_address_i,
        output read_i, read_address_i, ack_i,
        input  read_data_o, irq_o, vector_o
    );

endinterface

// File: rtl/intc_priority_encoder.sv
// Combinational lowest-index-wins priority encoder.
module intc_priority_encoder #(
    parameter int SOURCES     = 8,
    parameter int INDEX_WIDTH = (SOURCES > 1) ? $clog2(SOURCES) : 1
) (
    input  logic [SOURCES-1:0]     req_i,
    output logic                   valid_o,
    output logic [INDEX_WIDTH-1:0] index_o
);

    // Scanning downward lets the lowest set bit overwrite any higher one.
    always_comb begin
        valid_o = |req_i;
        index_o = '0;
        for (int i = SOURCES - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                index_o = INDEX_WIDTH'(i);
            end
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// Latches peripheral interrupts, masks and prioritises them, and runs the
// request/acknowledge/complete handshake with the CPU.
module interrupt_controller
    import intc_pkg::*;
#(
    parameter int SOURCES      = 8,
    parameter int VECTOR_WIDTH = (SOURCES > 1) ? $clog2(SOURCES) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [SOURCES-1:0]     irq_src_i,
    interrupt_controller_if.slave  bus,
    output intc_state_e            state_o
);

    logic [SOURCES-1:0]      enable_q;
    logic [SOURCES-1:0]      pending_q;
    logic [SOURCES-1:0]      pending_d;
    logic [SOURCES-1:0]      trigger_q;
    logic [SOURCES-1:0]      in_service_q;
    logic [SOURCES-1:0]      in_service_d;
    logic [SOURCES-1:0]      prev_q;

    intc_state_e             state_q;
    intc_state_e             state_d;
    logic                    irq_q;
    logic                    irq_d;
    logic [VECTOR_WIDTH-1:0] vector_q;
    logic [VECTOR_WIDTH-1:0] vector_d;

    logic [SOURCES-1:0]      eligible;
    logic [SOURCES-1:0]      rise;
    logic [SOURCES-1:0]      w1c_mask;
    logic [SOURCES-1:0]      ack_clear;
    logic [SOURCES-1:0]      vec_onehot;
    logic [SOURCES-1:0]      wdata;
    logic                    win_valid;
    logic [VECTOR_WIDTH-1:0] win_index;

    logic                    wr_enable;
    logic                    wr_pending;
    logic                    wr_trigger;
    logic                    wr_complete;
    logic                    complete_match;
    reg_data_t               rdata;
    logic                    unused_inputs;

    assign wdata          = bus.write_data_i[SOURCES-1:0];
    assign wr_enable      = bus.write_i && (bus.write_address_i == ADDR_ENABLE);
    assign wr_pending     = bus.write_i && (bus.write_address_i == ADDR_PENDING);
    assign wr_trigger     = bus.write_i && (bus.write_address_i == ADDR_TRIGGER);
    assign wr_complete    = bus.write_i && (bus.write_address_i == ADDR_COMPLETE);
    assign complete_match = wr_complete && (bus.write_data_i[VECTOR_WIDTH-1:0] == vector_q);

    // Reads have no side effects, so the strobe itself carries no information.
    assign unused_inputs = ^{bus.read_i, bus.write_data_i};

    assign eligible = pending_q & enable_q;
    assign rise     = irq_src_i & ~prev_q;
    assign w1c_mask = wr_pending ? wdata : '0;

    intc_priority_encoder #(
        .SOURCES     (SOURCES),
        .INDEX_WIDTH (VECTOR_WIDTH)
    ) u_prio (
        .req_i   (eligible),
        .valid_o (win_valid),
        .index_o (win_index)
    );

    always_comb begin
        vec_onehot           = '0;
        vec_onehot[vector_q] = 1'b1;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d      = state_q;
        irq_d        = irq_q;
        vector_d     = vector_q;
        in_service_d = in_service_q;
        ack_clear    = '0;
        case (state_q)
            IDLE: begin
                if (win_valid) begin
                    vector_d = win_index;
                    irq_d    = 1'b1;
                    state_d  = REQUEST;
                end
            end
            REQUEST: begin
                if (bus.ack_i) begin
                    ack_clear    = vec_onehot & trigger_q;
                    in_service_d = vec_onehot;
                    irq_d        = 1'b0;
                    state_d      = SERVICE;
                end else if (!(|(vec_onehot & enable_q & pending_q))) begin
                    irq_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            SERVICE: begin
                irq_d = 1'b0;
                if (complete_match) begin
                    in_service_d = '0;
                    state_d      = IDLE;
                end
            end
            default: begin
                irq_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // Edge bits: a new rising edge beats any clear in the same cycle.
    // Level bits simply follow the input and ignore clears.
    assign pending_d = (trigger_q & ((pending_q & ~(w1c_mask | ack_clear)) | rise))
                     | (~trigger_q & irq_src_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            irq_q        <= 1'b0;
            vector_q     <= '0;
            in_service_q <= '0;
        end else begin
            state_q      <= state_d;
            irq_q        <= irq_d;
            vector_q     <= vector_d;
            in_service_q <= in_service_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            enable_q  <= '0;
            trigger_q <= '0;
            pending_q <= '0;
            prev_q    <= '0;
        end else begin
            prev_q    <= irq_src_i;
            pending_q <= pending_d;
            if (wr_enable) begin
                enable_q <= wdata;
            end
            if (wr_trigger) begin
                trigger_q <= wdata;
            end
        end
    end

    always_comb begin
        rdata = '0;
        case (bus.read_address_i)
            ADDR_ENABLE:     rdata[SOURCES-1:0]    = enable_q;
            ADDR_PENDING:    rdata[SOURCES-1:0]    = pending_q;
            ADDR_TRIGGER:    rdata[SOURCES-1:0]    = trigger_q;
            ADDR_IN_SERVICE: rdata[SOURCES-1:0]    = in_service_q;
            ADDR_STATUS:     rdata[VECTOR_WIDTH:0] = {vector_q, irq_q};
            default:         rdata = '0;
        endcase
    end

    assign bus.read_data_o = rdata;
    assign bus.irq_o       = irq_q;
    assign bus.vector_o    = vector_q;
    assign state_o         = state_q;

    a_in_service_onehot0: assert property (@(posedge clk_i) disable iff (rst_i)
        $onehot0(in_service_q));
    a_irq_only_in_request: assert property (@(posedge clk_i) disable iff (rst_i)
        irq_q == (state_q == REQUEST));

endmodule

// File: tb/tb_interrupt_controller.sv
// Randomised and directed bench for interrupt_controller, checked every cycle
// against a behavioural model of the register map and CPU handshake.
module tb_interrupt_controller;
    import intc_pkg::*;

    localparam int SOURCES = 8;
    localparam int VW      = 3;
    localparam int unsigned SMASK = 32'h0000_00FF;

    localparam int PH_IDLE = 0;
    localparam int PH_WAIT = 1;
    localparam int PH_SVC  = 2;

    // ---------------- clock / reset ----------------
    logic               clk_i = 1'b0;
    logic               rst_i;
    logic [SOURCES-1:0] irq_src;
    intc_state_e        state_dbg;

    always #20 clk_i = ~clk_i;

    interrupt_controller_if #(.VECTOR_WIDTH(VW)) bus ();

    interrupt_controller #(
        .SOURCES      (SOURCES),
        .VECTOR_WIDTH (VW)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .irq_src_i (irq_src),
        .bus       (bus),
        .state_o   (state_dbg)
    );

    // ---------------- scoreboard ----------------
    int n_total = 0;
    int n_bad   = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int unsigned m_en, m_pend, m_trig, m_insvc, m_prev, m_vec;
    bit          m_irq;
    int          m_phase;

    function automatic void model_reset();
        m_en = 0; m_pend = 0; m_trig = 0; m_insvc = 0; m_prev = 0;
        m_vec = 0; m_irq = 0; m_phase = PH_IDLE;
    endfunction

    function automatic int unsigned bit_of(int unsigned v, int unsigned i);
        return (v >> i) & 1;
    endfunction

    function automatic void model_step();
        int unsigned src, wa, wd, clr, eligible, pend_n;
        bit          wr;
        int unsigned en_n, trig_n, insvc_n, vec_n;
        bit          irq_n;
        int          phase_n;
        src = 32'(irq_src);
        wr  = bus.write_i;
        wa  = 32'(bus.write_address_i);
        wd  = bus.write_data_i & SMASK;
        clr = 0;
        en_n = m_en; trig_n = m_trig; insvc_n = m_insvc;
        vec_n = m_vec; irq_n = m_irq; phase_n = m_phase;
        eligible = m_pend & m_en;
        case (m_phase)
            PH_IDLE: begin
                if (eligible != 0) begin
                    for (int i = SOURCES - 1; i >= 0; i--)
                        if (bit_of(eligible, i) == 1) vec_n = i;
                    irq_n = 1; phase_n = PH_WAIT;
                end
            end
            PH_WAIT: begin
                if (bus.ack_i) begin
                    clr     = 1 << m_vec;
                    insvc_n = 1 << m_vec;
                    irq_n   = 0; phase_n = PH_SVC;
                end else if (bit_of(m_en & m_pend, m_vec) == 0) begin
                    irq_n = 0; phase_n = PH_IDLE;
                end
            end
            default: begin
                if (wr && wa == 4 && (bus.write_data_i % (1 << VW)) == m_vec) begin
                    insvc_n = 0; phase_n = PH_IDLE;
                end
            end
        endcase
        if (wr && wa == 1) clr |= wd;
        pend_n = 0;
        for (int i = 0; i < SOURCES; i++) begin
            if (bit_of(m_trig, i) == 1) begin
                if ((bit_of(m_pend, i) == 1 && bit_of(clr, i) == 0) ||
                    (bit_of(src, i) == 1 && bit_of(m_prev, i) == 0))
                    pend_n |= (1 << i);
            end else if (bit_of(src, i) == 1) begin
                pend_n |= (1 << i);
            end
        end
        if (wr && wa == 0) en_n = wd;
        if (wr && wa == 2) trig_n = wd;
        m_en = en_n; m_trig = trig_n; m_pend = pend_n; m_insvc = insvc_n;
        m_vec = vec_n; m_irq = irq_n; m_phase = phase_n; m_prev = src;
    endfunction

    function automatic int unsigned read_expect(int a);
        case (a)
            0: return m_en;
            1: return m_pend;
            2: return m_trig;
            3: return m_insvc;
            5: return (m_vec << 1) | 32'(m_irq);
            default: return 0;
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    task automatic check_outputs();
        check("irq_o", 32'(bus.irq_o), 32'(m_irq));
        check("vector_o", 32'(bus.vector_o), m_vec);
        for (int a = 0; a < 8; a++) exp_q.push_back(read_expect(a));
        for (int a = 0; a < 8; a++) begin
            bus.read_address_i = 3'(a);
            #1;
            check($sformatf("read_reg%0d", a), bus.read_data_o, exp_q.pop_front());
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        if (rst_i) model_reset(); else model_step();
        @(negedge clk_i);
        check_outputs();
    endtask

    task automatic drive(input bit wr, input logic [2:0] wa, input logic [31:0] wd, input bit ack);
        bus.write_i = wr; bus.write_address_i = wa; bus.write_data_i = wd; bus.ack_i = ack;
        tick();
        bus.write_i = 1'b0; bus.ack_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 3'd0, 32'h0, 1'b0);
    endtask

    task automatic reg_write(input logic [2:0] a, input logic [31:0] d);
        drive(1'b1, a, d, 1'b0);
    endtask

    task automatic ack_pulse();
        drive(1'b0, 3'd0, 32'h0, 1'b1);
    endtask

    task automatic read_dut(input logic [2:0] a, output logic [31:0] d);
        bus.read_address_i = a;
        #1;
        d = bus.read_data_o;
    endtask

    // Asserts reset at a falling edge and checks it acts before any clock edge.
    task automatic apply_reset();
        logic [31:0] d;
        bus.write_i = 1'b0; bus.ack_i = 1'b0; irq_src = '0;
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        model_reset();
        check("rst_irq_o", 32'(bus.irq_o), 32'h0);
        read_dut(ADDR_ENABLE, d);     check("rst_enable", d, 32'h0);
        read_dut(ADDR_IN_SERVICE, d); check("rst_in_service", d, 32'h0);
        read_dut(ADDR_STATUS, d);     check("rst_status", d, 32'h0);
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] d;
        rst_i = 1'b1;
        irq_src = '0;
        bus.write_i = 1'b0; bus.write_data_i = '0; bus.write_address_i = '0;
        bus.read_i = 1'b1; bus.read_address_i = '0; bus.ack_i = 1'b0;
        model_reset();
        apply_reset();

        // Basic edge request, ack and complete.
        reg_write(ADDR_ENABLE, 32'h04);
        reg_write(ADDR_TRIGGER, 32'h04);
        irq_src[2] = 1'b1; idle(1);
        check("t1_no_irq_yet", 32'(bus.irq_o), 32'h0);
        irq_src = '0; idle(1);
        check("t1_irq", 32'(bus.irq_o), 32'h1);
        check("t1_vector", 32'(bus.vector_o), 32'h2);
        read_dut(ADDR_STATUS, d); check("t1_status", d, 32'h5);
        ack_pulse();
        read_dut(ADDR_PENDING, d);    check("t1_pending_cleared", d, 32'h0);
        read_dut(ADDR_IN_SERVICE, d); check("t1_in_service", d, 32'h04);
        reg_write(ADDR_COMPLETE, 32'h2);
        read_dut(ADDR_IN_SERVICE, d); check("t1_in_service_done", d, 32'h0);
        check("t1_state_idle", 32'(state_dbg), 32'(IDLE));

        // Priority between two simultaneous edges.
        apply_reset();
        reg_write(ADDR_ENABLE, 32'hFF);
        reg_write(ADDR_TRIGGER, 32'hFF);
        irq_src = 8'h28; idle(1);
        irq_src = '0; idle(1);
        check("t2_first_vector", 32'(bus.vector_o), 32'h3);
        ack_pulse();
        reg_write(ADDR_COMPLETE, 32'h7);
        check("t2_wrong_complete_ignored", 32'(state_dbg), 32'(SERVICE));
        reg_write(ADDR_COMPLETE, 32'h3);
        idle(1);
        check("t2_second_irq", 32'(bus.irq_o), 32'h1);
        check("t2_second_vector", 32'(bus.vector_o), 32'h5);
        ack_pulse();
        reg_write(ADDR_COMPLETE, 32'h5);

        // Withdrawal by masking before ack.
        apply_reset();
        reg_write(ADDR_ENABLE, 32'h01);
        reg_write(ADDR_TRIGGER, 32'h01);
        irq_src[0] = 1'b1; idle(1);
        irq_src = '0; idle(1);
        check("t3_irq", 32'(bus.irq_o), 32'h1);
        reg_write(ADDR_ENABLE, 32'h00);
        idle(1);
        check("t3_withdrawn", 32'(bus.irq_o), 32'h0);
        read_dut(ADDR_PENDING, d); check("t3_pending_kept", d, 32'h01);

        // Level mode: held source re-requests right after complete.
        apply_reset();
        reg_write(ADDR_ENABLE, 32'h02);
        irq_src[1] = 1'b1; idle(2);
        check("t4_irq", 32'(bus.irq_o), 32'h1);
        check("t4_vector", 32'(bus.vector_o), 32'h1);
        ack_pulse();
        read_dut(ADDR_PENDING, d); check("t4_level_pending_held", d, 32'h02);
        reg_write(ADDR_COMPLETE, 32'h1);
        check("t4_irq_low_at_complete", 32'(bus.irq_o), 32'h0);
        idle(1);
        check("t4_rerequest", 32'(bus.irq_o), 32'h1);
        irq_src = '0; idle(1);
        read_dut(ADDR_PENDING, d); check("t4_pending_dropped", d, 32'h0);
        idle(2);

        // W1C in the same cycle as a new edge: the edge wins.
        apply_reset();
        reg_write(ADDR_TRIGGER, 32'h01);
        idle(1);
        irq_src[0] = 1'b1;
        reg_write(ADDR_PENDING, 32'h01);
        read_dut(ADDR_PENDING, d); check("t5_set_wins", d, 32'h01);
        irq_src = '0;
        reg_write(ADDR_PENDING, 32'h01);
        read_dut(ADDR_PENDING, d); check("t5_w1c", d, 32'h0);

        // Reset while in service, then stray ack/complete.
        apply_reset();
        reg_write(ADDR_ENABLE, 32'h04);
        reg_write(ADDR_TRIGGER, 32'h04);
        irq_src[2] = 1'b1; idle(1);
        irq_src = '0; idle(1);
        ack_pulse();
        check("t6_in_service_state", 32'(state_dbg), 32'(SERVICE));
        apply_reset();
        ack_pulse();
        reg_write(ADDR_COMPLETE, 32'h2);
        read_dut(ADDR_IN_SERVICE, d); check("t6_in_service_after", d, 32'h0);
        check("t6_irq_after", 32'(bus.irq_o), 32'h0);

        // Randomised traffic against the model.
        apply_reset();
        for (int c = 0; c < 1500; c++) begin
            int unsigned op;
            irq_src = irq_src ^ SOURCES'($urandom & $urandom & $urandom);
            op = $urandom_range(0, 9);
            case (op)
                0, 1: reg_write(3'($urandom_range(0, 7)), $urandom);
                2:    reg_write(ADDR_COMPLETE, (op == 2 && $urandom_range(0, 3) != 0) ? m_vec : $urandom);
                3, 4: ack_pulse();
                default: idle(1);
            endcase
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

endmodule
